// File: rtl/ysyx_22040632_csr_seq_if.sv
// rtl/ysyx_22040632_csr_seq_if.sv - writeback-to-sequencer retire handshake
interface ysyx_22040632_csr_seq_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic            in_wen_csr;
  logic [11:0]     in_csr_addr;
  logic [XLEN-1:0] in_csr_wdata;
  logic            in_ecall;
  logic [XLEN-1:0] in_no;
  logic [XLEN-1:0] in_pc;
  logic            in_mret;

  modport master (
    output in_valid, in_wen_csr, in_csr_addr, in_csr_wdata,
    output in_ecall, in_no, in_pc, in_mret,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_wen_csr, in_csr_addr, in_csr_wdata,
    input  in_ecall, in_no, in_pc, in_mret,
    output in_ready
  );
endinterface

// File: rtl/ysyx_22040632_csr_seq.sv
// rtl/ysyx_22040632_csr_seq.sv - expands retiring csrw/ecall/mret into single-port CSR writes
module ysyx_22040632_csr_seq #(
  parameter int XLEN = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  ysyx_22040632_csr_seq_if.slave         wb,
  input  logic [XLEN-1:0]                mstatus_rdata,
  output logic                           csr_we,
  output logic [11:0]                    csr_waddr,
  output logic [XLEN-1:0]                csr_wdata,
  output logic                           trap_done,
  output logic                           seq_err
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE,
    W_CSR,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] no_q, no_d;
  logic            we_d;
  logic [11:0]     waddr_d;
  logic [XLEN-1:0] wdata_d;
  logic            trap_d;
  logic            accept;
  logic            multi_flag;
  logic [XLEN-1:0] mret_src;

  function automatic logic [XLEN-1:0] ecall_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  assign wb.in_ready  = (state_q == IDLE) || (state_q == W_CSR) || (state_q == W_MSTATUS);
  assign accept       = wb.in_valid && wb.in_ready;
  assign multi_flag   = (wb.in_ecall && wb.in_mret) || (wb.in_ecall && wb.in_wen_csr) ||
                        (wb.in_mret && wb.in_wen_csr);
  // An mstatus write leaving this cycle is not yet visible in mstatus_rdata.
  assign mret_src     = (csr_we && csr_waddr == ADDR_MSTATUS) ? csr_wdata : mstatus_rdata;

  always_comb begin
    state_d = state_q;
    no_d    = no_q;
    we_d    = 1'b0;
    waddr_d = csr_waddr;
    wdata_d = csr_wdata;
    trap_d  = 1'b0;
    if (accept) begin
      if (wb.in_ecall) begin
        state_d = W_MEPC;
        no_d    = wb.in_no;
        we_d    = 1'b1;
        waddr_d = ADDR_MEPC;
        wdata_d = wb.in_pc;
      end else if (wb.in_mret) begin
        state_d = W_MSTATUS;
        we_d    = 1'b1;
        waddr_d = ADDR_MSTATUS;
        wdata_d = mret_mstatus(mret_src);
        trap_d  = 1'b1;
      end else if (wb.in_wen_csr) begin
        state_d = W_CSR;
        we_d    = 1'b1;
        waddr_d = wb.in_csr_addr;
        wdata_d = wb.in_csr_wdata;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        W_MEPC: begin
          state_d = W_MCAUSE;
          we_d    = 1'b1;
          waddr_d = ADDR_MCAUSE;
          wdata_d = no_q;
        end
        W_MCAUSE: begin
          state_d = W_MSTATUS;
          we_d    = 1'b1;
          waddr_d = ADDR_MSTATUS;
          wdata_d = ecall_mstatus(mstatus_rdata);
          trap_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      no_q      <= '0;
      csr_we    <= 1'b0;
      csr_waddr <= '0;
      csr_wdata <= '0;
      trap_done <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      no_q      <= no_d;
      csr_we    <= we_d;
      csr_waddr <= waddr_d;
      csr_wdata <= wdata_d;
      trap_done <= trap_d;
      if (accept && multi_flag) seq_err <= 1'b1;
    end
  end

endmodule
